// File: rtl/m_ext_pkg.sv
// Shared RV32M definitions: opcodes, divider FSM states and constants.
// Also used by the multiplier for mul_opcode.
package m_ext_pkg;

  typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIN} div_state_e;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract.
module div_restore_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dvd_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic            q_bit
);
  logic [XLEN:0] trial, diff;

  // 33-bit trial so divisors >= 2^31 compare correctly
  assign trial   = {rem, dvd_msb};
  assign diff    = trial - {1'b0, divisor};
  assign q_bit   = ~diff[XLEN];
  assign rem_nxt = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];
endmodule

// File: rtl/divider_iterative.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU (33 cycles, 1 for special cases).
// Optional macro DIV_EARLY_TERM_EN: finish in 1 cycle when |dividend| < |divisor|.
module divider_iterative
  import m_ext_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startE,
  input  logic [1:0]      div_opcode,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic [XLEN-1:0] result_divide,
  output logic            done,
  output logic            div_use
);
  div_state_e      state;
  div_op_e         op;
  logic [XLEN-1:0] dvd, dsr, rem, quo;
  logic [CNT_W-1:0] count;
  logic            neg_q, neg_r;

  logic            sgn_op, s1, s2, dz, ovf, early;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN-1:0] rem_nxt, q_fin, fin_res;
  logic            q_bit;

  assign sgn_op = ~div_opcode[0];
  assign s1     = sgn_op & operand1[XLEN-1];
  assign s2     = sgn_op & operand2[XLEN-1];
  assign abs1   = neg_if(operand1, s1);
  assign abs2   = neg_if(operand2, s2);
  assign dz     = (operand2 == '0);
  assign ovf    = sgn_op && (operand1 == INT_MIN) && (operand2 == ALL_ONES);
`ifdef DIV_EARLY_TERM_EN
  assign early  = !dz && (abs1 < abs2);
`else
  assign early  = 1'b0;
`endif

  div_restore_step #(.XLEN(XLEN)) u_step (
    .rem     (rem),
    .dvd_msb (dvd[XLEN-1]),
    .divisor (dsr),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  // Final step result is corrected and registered on the way into FIN
  assign q_fin   = {quo[XLEN-2:0], q_bit};
  assign fin_res = op[1] ? neg_if(rem_nxt, neg_r) : neg_if(q_fin, neg_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      op            <= DIV;
      dvd           <= '0;
      dsr           <= '0;
      rem           <= '0;
      quo           <= '0;
      count         <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      result_divide <= '0;
      done          <= 1'b0;
      div_use       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          div_use <= 1'b0;
          if (startE) begin
            op      <= div_op_e'(div_opcode);
            div_use <= 1'b1;
            if (dz) begin
              result_divide <= div_opcode[1] ? operand1 : ALL_ONES;
              done          <= 1'b1;
              state         <= FIN;
            end else if (ovf) begin
              result_divide <= div_opcode[1] ? '0 : INT_MIN;
              done          <= 1'b1;
              state         <= FIN;
            end else if (early) begin
              // |rem| = |dividend| with dividend's sign is operand1 itself
              result_divide <= div_opcode[1] ? operand1 : '0;
              done          <= 1'b1;
              state         <= FIN;
            end else begin
              dvd   <= abs1;
              dsr   <= abs2;
              rem   <= '0;
              quo   <= '0;
              count <= '0;
              neg_q <= s1 ^ s2;
              neg_r <= s1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem   <= rem_nxt;
          quo   <= q_fin;
          dvd   <= {dvd[XLEN-2:0], 1'b0};
          count <= count + 1'b1;
          if (count == CNT_W'(DIV_ITERS - 1)) begin
            result_divide <= fin_res;
            done          <= 1'b1;
            state         <= FIN;
          end
        end
        FIN: begin
          done    <= 1'b0;
          div_use <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
